// File: rtl/minmax_meas_mc_if.sv
// Sample/measurement bus for the multi-channel min/max meter.
// master drives samples and control; slave (the meter) returns results.
interface minmax_meas_mc_if #(
    parameter int DW = 12,
    parameter int RW = 10,
    parameter int CH = 2
);
    logic                data_valid;
    logic [CH*DW-1:0]    data_in;
    logic [RW-1:0]       range;
    logic                peak_hold;
    logic                clear;
    logic [CH*DW-1:0]    max_out;
    logic [CH*DW-1:0]    min_out;
    logic [CH*DW-1:0]    pp_out;
    logic                meas_valid;

    modport master (
        output data_valid, data_in, range, peak_hold, clear,
        input  max_out, min_out, pp_out, meas_valid
    );

    modport slave (
        input  data_valid, data_in, range, peak_hold, clear,
        output max_out, min_out, pp_out, meas_valid
    );
endinterface

// File: rtl/minmax_meas_mc.sv
// Multi-channel windowed signed max/min/peak-to-peak meter.
// All channels share one window counter and sample strobe; results for every
// channel are published together with a single-cycle meas_valid.
module minmax_meas_mc #(
    parameter int DW = 12,
    parameter int RW = 10,
    parameter int CH = 2
) (
    input  logic              clk_in,
    input  logic              rst_n,
    minmax_meas_mc_if.slave   bus
);

    typedef enum logic [1:0] {
        S_FIRST = 2'd0,
        S_ACC   = 2'd1,
        S_CONT  = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [RW-1:0]          r_win_len;
    logic [RW-1:0]          r_count;
    logic [RW-1:0]          w_count_nxt;
    logic                   r_held;
    logic                   w_complete;
    logic                   w_seed;
    logic                   w_load_acc;
    logic                   w_latch_len;

    logic signed [DW-1:0]   r_acc_max [CH];
    logic signed [DW-1:0]   r_acc_min [CH];
    logic signed [DW-1:0]   w_samp    [CH];
    logic signed [DW-1:0]   w_max_nxt [CH];
    logic signed [DW-1:0]   w_min_nxt [CH];

    logic [CH*DW-1:0]       r_max_out;
    logic [CH*DW-1:0]       r_min_out;
    logic [CH*DW-1:0]       r_pp_out;
    logic                   r_meas_valid;

    function automatic logic signed [DW-1:0] smax(input logic signed [DW-1:0] a,
                                                  input logic signed [DW-1:0] b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic signed [DW-1:0] smin(input logic signed [DW-1:0] a,
                                                  input logic signed [DW-1:0] b);
        return (a < b) ? a : b;
    endfunction

    // max - min is formed on sign-extended operands; the true difference never
    // exceeds 2^DW - 1, so dropping the top bit is lossless.
    function automatic logic [DW-1:0] pp_calc(input logic signed [DW-1:0] mx,
                                              input logic signed [DW-1:0] mn);
        return DW'({mx[DW-1], mx} - {mn[DW-1], mn});
    endfunction

    // Next-state and control decode; clear overrides any sample on the same edge.
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_complete  = 1'b0;
        w_seed      = 1'b0;
        w_load_acc  = 1'b0;
        w_latch_len = 1'b0;
        if (bus.clear) begin
            w_state_nxt = S_FIRST;
            w_count_nxt = '0;
        end else if (bus.data_valid) begin
            case (r_state)
                S_FIRST: begin
                    w_latch_len = 1'b1;
                    w_load_acc  = 1'b1;
                    if (bus.range == '0) begin
                        // Continuous mode starts from this sample and reports it.
                        w_seed      = 1'b1;
                        w_complete  = 1'b1;
                        w_count_nxt = '0;
                        w_state_nxt = S_CONT;
                    end else begin
                        w_seed = !(bus.peak_hold && r_held);
                        if (bus.range == RW'(1)) begin
                            w_complete  = 1'b1;
                            w_count_nxt = '0;
                        end else begin
                            w_count_nxt = RW'(1);
                            w_state_nxt = S_ACC;
                        end
                    end
                end
                S_ACC: begin
                    w_load_acc = 1'b1;
                    if (r_count + RW'(1) == r_win_len) begin
                        w_complete  = 1'b1;
                        w_count_nxt = '0;
                        w_state_nxt = S_FIRST;
                    end else begin
                        w_count_nxt = r_count + RW'(1);
                    end
                end
                S_CONT: begin
                    w_load_acc = 1'b1;
                    w_complete = 1'b1;
                end
                default: begin
                    w_state_nxt = S_FIRST;
                    w_count_nxt = '0;
                end
            endcase
        end
    end

    // Per-channel accumulator update: either seed with the sample or fold it in.
    always_comb begin
        for (int k = 0; k < CH; k++) begin
            w_samp[k]    = bus.data_in[k*DW +: DW];
            w_max_nxt[k] = w_seed ? w_samp[k] : smax(r_acc_max[k], w_samp[k]);
            w_min_nxt[k] = w_seed ? w_samp[k] : smin(r_acc_min[k], w_samp[k]);
        end
    end

    // Control registers: state, window length, sample count, peak-hold history.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_FIRST;
            r_count   <= '0;
            r_win_len <= '0;
            r_held    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            if (w_latch_len) begin
                r_win_len <= bus.range;
            end
            if (bus.clear) begin
                r_held <= 1'b0;
            end else if (w_complete) begin
                r_held <= 1'b1;
            end
        end
    end

    // Accumulator registers; clear discards them.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < CH; k++) begin
                r_acc_max[k] <= '0;
                r_acc_min[k] <= '0;
            end
        end else if (bus.clear) begin
            for (int k = 0; k < CH; k++) begin
                r_acc_max[k] <= '0;
                r_acc_min[k] <= '0;
            end
        end else if (w_load_acc) begin
            for (int k = 0; k < CH; k++) begin
                r_acc_max[k] <= w_max_nxt[k];
                r_acc_min[k] <= w_min_nxt[k];
            end
        end
    end

    // Result registers: load on window completion, otherwise hold; strobe is one cycle.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_max_out    <= '0;
            r_min_out    <= '0;
            r_pp_out     <= '0;
            r_meas_valid <= 1'b0;
        end else begin
            r_meas_valid <= w_complete;
            if (w_complete) begin
                for (int k = 0; k < CH; k++) begin
                    r_max_out[k*DW +: DW] <= w_max_nxt[k];
                    r_min_out[k*DW +: DW] <= w_min_nxt[k];
                    r_pp_out[k*DW +: DW]  <= pp_calc(w_max_nxt[k], w_min_nxt[k]);
                end
            end
        end
    end

    assign bus.max_out    = r_max_out;
    assign bus.min_out    = r_min_out;
    assign bus.pp_out     = r_pp_out;
    assign bus.meas_valid = r_meas_valid;

endmodule

// File: tb/tb_minmax_meas_mc.sv
// Directed bench for minmax_meas_mc with a result scoreboard.
module tb_minmax_meas_mc;
    localparam int DW = 12;
    localparam int RW = 10;
    localparam int CH = 2;

    typedef struct packed {
        logic [CH*DW-1:0] mx;
        logic [CH*DW-1:0] mn;
        logic [CH*DW-1:0] pp;
    } exp_t;

    logic clk_in = 1'b0;
    logic rst_n;
    exp_t sb[$];
    int   checks  = 0;
    int   errors  = 0;
    int   n_push  = 0;
    int   n_valid = 0;

    always #5 clk_in = ~clk_in;

    minmax_meas_mc_if #(.DW(DW), .RW(RW), .CH(CH)) bus ();

    minmax_meas_mc #(.DW(DW), .RW(RW), .CH(CH)) dut (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    task automatic check(input string tag, input logic [CH*DW-1:0] got,
                         input logic [CH*DW-1:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, want);
        end
    endtask

    // Expected result for a completed window: per-channel max/min, pp = max - min.
    task automatic push(input int mx0, input int mn0, input int mx1, input int mn1);
        exp_t e;
        e.mx = {DW'(mx1), DW'(mx0)};
        e.mn = {DW'(mn1), DW'(mn0)};
        e.pp = {DW'(mx1 - mn1), DW'(mx0 - mn0)};
        sb.push_back(e);
        n_push++;
    endtask

    task automatic drive(input bit v, input int d0, input int d1, input bit c);
        @(negedge clk_in);
        bus.data_valid = v;
        bus.data_in    = {DW'(d1), DW'(d0)};
        bus.clear      = c;
    endtask

    task automatic samp(input int d0, input int d1);
        drive(1'b1, d0, d1, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 0, 0, 1'b0);
    endtask

    // Scoreboard consumer: every meas_valid must match the oldest pending result.
    always @(negedge clk_in) begin
        if (rst_n === 1'b1 && bus.meas_valid === 1'b1) begin
            n_valid++;
            checks++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_valid: observed meas_valid=1 expected 0 (no pending result)");
            end
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                check("max_out", bus.max_out, e.mx);
                check("min_out", bus.min_out, e.mn);
                check("pp_out",  bus.pp_out,  e.pp);
            end
        end
    end

    initial begin
        bus.data_valid = 1'b0;
        bus.data_in    = '0;
        bus.range      = RW'(4);
        bus.peak_hold  = 1'b0;
        bus.clear      = 1'b0;
        rst_n          = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        check("rst_max",   bus.max_out, '0);
        check("rst_min",   bus.min_out, '0);
        check("rst_pp",    bus.pp_out,  '0);
        check("rst_valid", {{(CH*DW-1){1'b0}}, bus.meas_valid}, '0);
        idle(2);
        @(negedge clk_in);
        rst_n = 1'b1;
        idle(1);

        // Window of 4 with a negative constant channel.
        samp(5, -2048);
        samp(-3, -2048);
        samp(100, -2048);
        samp(7, -2048);
        push(100, -3, -2048, -2048);
        idle(2);

        // Sparse valids, full-scale extremes, then a back-to-back window.
        samp(2047, 0);
        idle(1);
        samp(-2048, 0);
        idle(1);
        samp(0, 0);
        idle(1);
        samp(1, 0);
        push(2047, -2048, 0, 0);
        samp(1, -1);
        samp(2, -2);
        samp(3, -3);
        samp(4, -4);
        push(4, 1, -1, -4);
        idle(2);

        // Continuous mode: every sample reports the running extremes.
        bus.range = '0;
        samp(3, 0);
        push(3, 3, 0, 0);
        samp(1, 0);
        push(3, 1, 0, 0);
        samp(9, 0);
        push(9, 1, 0, 0);
        bus.range = RW'(3);
        drive(1'b0, 0, 0, 1'b1);
        idle(2);

        // Peak hold across windows, then clear restarts the history.
        bus.peak_hold = 1'b1;
        samp(10, 0);
        samp(20, 0);
        samp(30, 0);
        push(30, 10, 0, 0);
        samp(0, 0);
        samp(5, 0);
        samp(6, 0);
        push(30, 0, 0, 0);
        drive(1'b0, 0, 0, 1'b1);
        samp(4, 0);
        samp(4, 0);
        samp(4, 0);
        push(4, 4, 0, 0);
        idle(2);
        bus.peak_hold = 1'b0;

        // Asynchronous reset mid-window, then clear coinciding with a sample.
        bus.range = RW'(8);
        for (int i = 0; i < 5; i++) samp(50 + i, 0);
        @(negedge clk_in);
        bus.data_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("midrst_max",   bus.max_out, '0);
        check("midrst_min",   bus.min_out, '0);
        check("midrst_pp",    bus.pp_out,  '0);
        check("midrst_valid", {{(CH*DW-1){1'b0}}, bus.meas_valid}, '0);
        @(negedge clk_in);
        rst_n = 1'b1;
        drive(1'b1, 1000, 1000, 1'b1);
        for (int i = 0; i < 8; i++) begin
            samp(-1 - i, i);
        end
        push(-1, -8, 7, 0);
        idle(2);

        // Range change mid-window applies to the next window only.
        bus.range = RW'(4);
        samp(1, 0);
        samp(2, 0);
        bus.range = RW'(2);
        samp(3, 0);
        samp(4, 0);
        push(4, 1, 0, 0);
        samp(9, 0);
        samp(8, 0);
        push(9, 8, 0, 0);
        idle(1);

        // Window of one: every sample completes with pp = 0.
        bus.range = RW'(1);
        samp(-5, 3);
        push(-5, -5, 3, 3);
        samp(7, 3);
        push(7, 7, 3, 3);
        idle(4);

        check("valid_count", (CH*DW)'(n_valid), (CH*DW)'(n_push));
        check("sb_drained",  (CH*DW)'(sb.size()), '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
